branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 16 +
 rtl/branch_predictor_sat_counter.sv | 19 +
 rtl/branch_predictor.sv | 108 ++++++++++
 tb/tb_branch_predictor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared widths, reset values and types for the branch predictor slice.
package branch_predictor_pkg;

  localparam int unsigned PC_W          = 32;
  localparam int unsigned BTB_IDX_W_DEF = 6;
  localparam int unsigned BHT_IDX_W_DEF = 8;
  localparam int unsigned TAG_W_DEF     = 10;
  localparam int unsigned CTR_W         = 2;

  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t BHT_RST = 2'b01;
  localparam ctr_t CTR_MAX = 2'b11;
  localparam ctr_t CTR_MIN = 2'b00;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Two-bit saturating counter next-state: up on taken, down on not-taken.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != CTR_MAX) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CTR_MIN) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus bimodal BHT predicting the next fetch address,
// with a one-cycle registered prediction stage.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned BTB_IDX_W = BTB_IDX_W_DEF,
  parameter int unsigned BHT_IDX_W = BHT_IDX_W_DEF,
  parameter int unsigned TAG_W     = TAG_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic        fetch_stall,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  output logic        pred_valid,
  output logic [31:0] pred_pc,
  output logic        pre_is_branch_taken,
  output logic [31:0] pre_branch_addr
);

  localparam int unsigned BTB_N   = 1 << BTB_IDX_W;
  localparam int unsigned BHT_N   = 1 << BHT_IDX_W;
  localparam int unsigned TAG_LSB = BTB_IDX_W + 2;
  localparam int unsigned TAG_MSB = BTB_IDX_W + TAG_W + 1;

  logic             btb_valid  [BTB_N];
  logic [TAG_W-1:0] btb_tag    [BTB_N];
  logic [PC_W-1:0]  btb_target [BTB_N];
  ctr_t             bht        [BHT_N];

  logic [BTB_IDX_W-1:0] f_btb_idx, u_btb_idx;
  logic [BHT_IDX_W-1:0] f_bht_idx, u_bht_idx;
  logic [TAG_W-1:0]     f_tag, u_tag;
  logic                 hit_c, taken_c;
  logic [PC_W-1:0]      addr_c;
  ctr_t                 ctr_next;
  logic                 unused_pc_bits;

  assign f_btb_idx = fetch_pc[BTB_IDX_W+1:2];
  assign f_bht_idx = fetch_pc[BHT_IDX_W+1:2];
  assign f_tag     = fetch_pc[TAG_MSB:TAG_LSB];
  assign u_btb_idx = update_pc[BTB_IDX_W+1:2];
  assign u_bht_idx = update_pc[BHT_IDX_W+1:2];
  assign u_tag     = update_pc[TAG_MSB:TAG_LSB];

  assign unused_pc_bits = ^{update_pc[PC_W-1:TAG_MSB+1], update_pc[1:0]};

  // Lookup reads table state only; same-cycle updates are not bypassed.
  always_comb begin
    hit_c   = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
    taken_c = hit_c && bht[f_bht_idx][1];
    addr_c  = taken_c ? btb_target[f_btb_idx] : fetch_pc + 32'd4;
  end

  bp_sat_counter u_sat_counter (
    .cnt      (bht[u_bht_idx]),
    .taken    (update_taken),
    .cnt_next (ctr_next)
  );

  // Flush wins over stall; stall freezes everything otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid          <= 1'b0;
      pred_pc             <= '0;
      pre_is_branch_taken <= 1'b0;
      pre_branch_addr     <= '0;
    end else if (flush) begin
      pred_valid <= 1'b0;
    end else if (!fetch_stall) begin
      pred_valid <= fetch_valid;
      if (fetch_valid) begin
        pred_pc             <= fetch_pc;
        pre_is_branch_taken <= taken_c;
        pre_branch_addr     <= addr_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_N; i++) bht[i] <= BHT_RST;
    end else if (update_en) begin
      bht[u_bht_idx] <= ctr_next;
    end
  end

  // Only taken outcomes allocate; not-taken leaves the entry alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_N; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (update_en && update_taken) begin
      btb_valid[u_btb_idx]  <= 1'b1;
      btb_tag[u_btb_idx]    <= u_tag;
      btb_target[u_btb_idx] <= update_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expected prediction pushed per driven
// cycle, popped and compared one cycle later.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_stall;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pre_is_branch_taken;
  logic [31:0] pre_branch_addr;

  typedef struct packed {
    logic        v;
    logic        chk;
    logic [31:0] pc;
    logic        t;
    logic [31:0] a;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  int    n_checks = 0;
  int    n_errors = 0;

  branch_predictor dut (
    .clk                 (clk),
    .rst                 (rst),
    .fetch_valid         (fetch_valid),
    .fetch_stall         (fetch_stall),
    .fetch_pc            (fetch_pc),
    .flush               (flush),
    .update_en           (update_en),
    .update_pc           (update_pc),
    .update_taken        (update_taken),
    .update_target       (update_target),
    .pred_valid          (pred_valid),
    .pred_pc             (pred_pc),
    .pre_is_branch_taken (pre_is_branch_taken),
    .pre_branch_addr     (pre_branch_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic st, input logic [31:0] pc, input logic fl,
                       input logic ue, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt);
    fetch_valid   = fv;
    fetch_stall   = st;
    fetch_pc      = pc;
    flush         = fl;
    update_en     = ue;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utgt;
  endtask

  task automatic push_pred(input string tag, input logic [31:0] pc, input logic t,
                           input logic [31:0] a);
    sb.push_back('{v: 1'b1, chk: 1'b1, pc: pc, t: t, a: a});
    sb_tag.push_back(tag);
  endtask

  task automatic push_idle(input string tag);
    sb.push_back('{v: 1'b0, chk: 1'b0, pc: 32'h0, t: 1'b0, a: 32'h0});
    sb_tag.push_back(tag);
  endtask

  // Advance one clock and compare the oldest expected prediction.
  task automatic cycle();
    exp_t  e;
    string tag;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e   = sb.pop_front();
      tag = sb_tag.pop_front();
      check({tag, "_valid"}, 32'(pred_valid), 32'(e.v));
      if (e.chk) begin
        check({tag, "_pc"}, pred_pc, e.pc);
        check({tag, "_taken"}, 32'(pre_is_branch_taken), 32'(e.t));
        check({tag, "_addr"}, pre_branch_addr, e.a);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    // Update during reset must be discarded.
    drive(1'b1, 1'b0, 32'h1c00_0000, 1'b0, 1'b1, 32'h1c00_0000, 1'b1, 32'h1c00_0999);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(pred_valid), 32'd0);
    check("rst_pc", pred_pc, 32'h0);
    check("rst_taken", 32'(pre_is_branch_taken), 32'd0);
    check("rst_addr", pre_branch_addr, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    #2;

    drive(1'b1, 1'b0, 32'h1c00_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    push_pred("cold", 32'h1c00_0000, 1'b0, 32'h1c00_0004);
    cycle();

    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1c00_0010, 1'b1, 32'h1c00_0100);
      push_idle("train_idle");
      cycle();
    end
    drive(1'b1, 1'b0, 32'h1c00_0010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    push_pred("trained", 32'h1c00_0010, 1'b1, 32'h1c00_0100);
    cycle();

    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1c00_0010, 1'b0, 32'h0);
    push_idle("nt1_idle");
    cycle();
    drive(1'b1, 1'b0, 32'h1c00_0010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    push_pred("hyst1", 32'h1c00_0010, 1'b1, 32'h1c00_0100);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1c00_0010, 1'b0, 32'h0);
    push_idle("nt2_idle");
    cycle();
    drive(1'b1, 1'b0, 32'h1c00_0010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    push_pred("hyst2", 32'h1c00_0010, 1'b0, 32'h1c00_0014);
    cycle();

    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1c00_0010, 1'b1, 32'h1c00_0100);
      push_idle("retrain_idle");
      cycle();
    end
    drive(1'b1, 1'b0, 32'h1c01_0010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    push_pred("alias", 32'h1c01_0010, 1'b0, 32'h1c01_0014);
    cycle();

    drive(1'b1, 1'b0, 32'h1c00_0010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    push_pred("pre_stall", 32'h1c00_0010, 1'b1, 32'h1c00_0100);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h1c01_0010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      push_pred("stall", 32'h1c00_0010, 1'b1, 32'h1c00_0100);
      cycle();
    end
    drive(1'b1, 1'b1, 32'h1c00_0000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    push_idle("flush");
    cycle();

    // Lookup and update to one index in the same cycle: old view first.
    drive(1'b1, 1'b0, 32'h1c00_0020, 1'b0, 1'b1, 32'h1c00_0020, 1'b1, 32'h1c00_0200);
    push_pred("same_old", 32'h1c00_0020, 1'b0, 32'h1c00_0024);
    cycle();
    drive(1'b1, 1'b0, 32'h1c00_0020, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    push_pred("same_new", 32'h1c00_0020, 1'b1, 32'h1c00_0200);
    cycle();

    drive(1'b1, 1'b0, 32'hffff_fffc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    push_pred("wrap", 32'hffff_fffc, 1'b0, 32'h0000_0000);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    push_idle("idle");
    cycle();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
